// File: rtl/iot_sensor_pkg.sv
// Shared types and limits for the sensor-side I2C arbitration logic.
package iot_sensor_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RELEASE
    } arb_state_e;

    localparam int ARB_MAX_REQ         = 8;
    localparam int ARB_DEFAULT_TIMEOUT = 20000;
    localparam int ARB_ID_W            = $clog2(ARB_MAX_REQ);

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set bit of pending scanning from ptr upward,
// wrapping at NUM_REQ.
module rr_priority_pick
    import iot_sensor_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]  pending,
    input  logic [ARB_ID_W-1:0] ptr,
    output logic [ARB_ID_W-1:0] winner,
    output logic                found
);

    logic [NUM_REQ-1:0] rotated;
    int                 sum;

    // Rotate so bit 0 is the ptr position; walking down means the lowest offset wins last.
    always_comb begin
        rotated = NUM_REQ'({pending, pending} >> ptr);
        winner  = '0;
        found   = 1'b0;
        sum     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = int'(ptr) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                winner = ARB_ID_W'(sum);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_sensor_arbiter.sv
// Round-robin owner of the shared I2C master: replays the granted sensor's command
// once per byte and routes done/error/data back to that sensor only.
//   state       | meaning
//   ARB_IDLE    | no owner; pick next pending requester and latch its command
//   ARB_ISSUE   | one-cycle i2c_start for the current byte, watchdog cleared
//   ARB_WAIT    | wait for done / NACK / watchdog expiry
//   ARB_RELEASE | drop grant, advance round-robin pointer past the owner
module i2c_sensor_arbiter
    import iot_sensor_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int BYTES_PER_GRANT = 2,
    parameter int TIMEOUT_CYCLES  = ARB_DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_start,
    input  logic [7*NUM_REQ-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]    req_rw_n,
    input  logic [8*NUM_REQ-1:0]  req_wdata,
    output logic [7:0]            req_rdata,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_ack_error,
    output logic                  i2c_start,
    output logic [6:0]            i2c_addr,
    output logic                  i2c_rw_n,
    output logic [7:0]            i2c_wdata,
    input  logic [7:0]            i2c_rdata,
    input  logic                  i2c_done,
    input  logic                  i2c_ack_error,
    output logic                  grant_valid,
    output logic [ARB_ID_W-1:0]   grant_id,
    output logic [7:0]            timeout_count
);

    localparam int BC_W = (BYTES_PER_GRANT > 1) ? $clog2(BYTES_PER_GRANT) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_e          state, state_nxt;
    logic [NUM_REQ-1:0]  pending;
    logic [ARB_ID_W-1:0] rr_ptr;
    logic [BC_W-1:0]     byte_cnt;
    logic [WD_W-1:0]     watchdog;
    logic [ARB_ID_W-1:0] winner;
    logic                found;
    logic [6:0]          sel_addr;
    logic                sel_rw_n;
    logic [7:0]          sel_wdata;
    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  clear_mask;
    logic                last_byte;
    logic                wd_expired;

    assign last_byte  = (byte_cnt == BC_W'(BYTES_PER_GRANT - 1));
    assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .winner  (winner),
        .found   (found)
    );

    always_comb begin
        sel_addr   = '0;
        sel_rw_n   = 1'b0;
        sel_wdata  = '0;
        owner_mask = '0;
        clear_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ARB_ID_W'(i)) begin
                sel_addr      = req_addr[7*i +: 7];
                sel_rw_n      = req_rw_n[i];
                sel_wdata     = req_wdata[8*i +: 8];
                clear_mask[i] = (state == ARB_IDLE) && found;
            end
            owner_mask[i] = (grant_id == ARB_ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:    if (found) state_nxt = ARB_ISSUE;
            ARB_ISSUE:   state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                if (i2c_ack_error) begin
                    state_nxt = ARB_RELEASE;
                end else if (i2c_done) begin
                    state_nxt = last_byte ? ARB_RELEASE : ARB_ISSUE;
                end else if (wd_expired) begin
                    state_nxt = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        i2c_start   = 1'b0;
        grant_valid = 1'b0;
        case (state)
            ARB_ISSUE: begin
                i2c_start   = 1'b1;
                grant_valid = 1'b1;
            end
            ARB_WAIT:  grant_valid = 1'b1;
            default:   ;
        endcase
    end

    // New request bits are OR-ed in after the clear, so a same-cycle re-request survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            rr_ptr        <= '0;
            byte_cnt      <= '0;
            watchdog      <= '0;
            timeout_count <= '0;
            grant_id      <= '0;
            i2c_addr      <= '0;
            i2c_rw_n      <= 1'b0;
            i2c_wdata     <= '0;
            req_rdata     <= '0;
            req_done      <= '0;
            req_ack_error <= '0;
        end else begin
            pending       <= (pending & ~clear_mask) | req_start;
            req_done      <= '0;
            req_ack_error <= '0;
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant_id  <= winner;
                        i2c_addr  <= sel_addr;
                        i2c_rw_n  <= sel_rw_n;
                        i2c_wdata <= sel_wdata;
                        byte_cnt  <= '0;
                    end
                end
                ARB_ISSUE: watchdog <= '0;
                ARB_WAIT: begin
                    if (i2c_ack_error) begin
                        req_ack_error <= owner_mask;
                    end else if (i2c_done) begin
                        req_rdata <= i2c_rdata;
                        req_done  <= owner_mask;
                        if (!last_byte) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (wd_expired) begin
                        req_ack_error <= owner_mask;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    rr_ptr <= (grant_id == ARB_ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
